serial_add_ctrl: RTL and testbench



---
 rtl/serial_add_ctrl.sv | 80 ++++++++
 tb/tb_serial_add_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: drives one full-adder cell bit-serially, LSB first, to form a WIDTH-bit add or subtract
module serial_add_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] op_a, op_b;
    logic [CNT_W-1:0] cnt;
    logic             carry, s, c, last;

    // the full-adder cell and MSB-step detect
    always_comb begin
        s    = op_a[0] ^ op_b[0] ^ carry;
        c    = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);
        last = cnt == CNT_W'(WIDTH - 1);
    end

    // next-state: accept in IDLE, step until the MSB, then one DONE cycle
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? RUN : IDLE;
            RUN:     state_nx = last ? DONE : RUN;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = state == RUN;
    assign done = state == DONE;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // datapath: subtraction is A + ~B + 1, with the +1 entering as the initial carry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a  <= '0;
            op_b  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (state == IDLE && start) begin
            op_a  <= A;
            op_b  <= sub ? ~B : B;
            carry <= sub;
            cnt   <= '0;
            sum   <= '0;
        end else if (state == RUN) begin
            sum   <= {s, sum[WIDTH-1:1]};
            op_a  <= op_a >> 1;
            op_b  <= op_b >> 1;
            carry <= c;
            cnt   <= last ? cnt : cnt + 1'b1;
            if (last) begin
                cout <= c;
                ovf  <= carry ^ c;
            end
        end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: randomized and directed checks of serial_add_ctrl against a timeline/arithmetic model
module tb_serial_add_ctrl;
    localparam int W = 4;

    logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0, sub = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic [W-1:0] sum;
    logic         cout, ovf, busy, done;
    int           passed = 0, total = 0;

    serial_add_ctrl #(.WIDTH(W), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .A(a), .B(b),
        .sum(sum), .cout(cout), .ovf(ovf), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // expected {ovf, cout, sum} from unsigned and signed arithmetic
    function automatic logic [W+1:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        int full, sx, sy, r;
        logic [W-1:0] ny;
        ny   = ~y;
        full = s ? int'(x) + int'(ny) + 1 : int'(x) + int'(y);
        sx   = x[W-1] ? int'(x) - (1 << W) : int'(x);
        sy   = y[W-1] ? int'(y) - (1 << W) : int'(y);
        r    = s ? sx - sy : sx + sy;
        return {(r < -(1 << (W-1))) || (r > (1 << (W-1)) - 1), full[W], full[W-1:0]};
    endfunction

    // model: m_cnt counts edges since accept (0 = idle, 1..W busy, W+1 done)
    int           m_cnt = 0;
    logic [W-1:0] m_sum = '0, p_sum = '0;
    logic         m_cout = 0, m_ovf = 0, p_cout = 0, p_ovf = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt = 0; m_sum = '0; m_cout = 0; m_ovf = 0;
        end else if (m_cnt == 0) begin
            if (start) begin
                m_cnt = 1;
                m_sum = '0;
                {p_ovf, p_cout, p_sum} = ref_op(a, b, sub);
            end
        end else if (m_cnt == W) begin
            m_cnt = W + 1; m_sum = p_sum; m_cout = p_cout; m_ovf = p_ovf;
        end else if (m_cnt == W + 1) m_cnt = 0;
        else m_cnt++;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("busy", busy, (m_cnt >= 1 && m_cnt <= W) ? 1 : 0);
            check("done", done, (m_cnt == W + 1) ? 1 : 0);
            check("busy_and_done", busy & done, 0);
            if (m_cnt == 0 || m_cnt == W + 1) begin
                check("sum", sum, m_sum);
                check("cout", cout, m_cout);
                check("ovf", ovf, m_ovf);
            end
        end
    end

    task automatic wait_done(output bit ok, output int nbusy);
        ok = 0; nbusy = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (done) begin ok = 1; break; end
        end
    endtask

    task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic s, input string name);
        bit got = 0;
        @(negedge clk); #1;
        a = x; b = y; sub = s; start = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) begin got = 1; break; end
        end
        check({name, " accept"}, got, 1);
        #1;
        start = 0; a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
    endtask

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s, input string name,
                          input int es, input int ec, input int eo);
        bit ok; int nb;
        launch(x, y, s, name);
        wait_done(ok, nb);
        check({name, " done"}, ok, 1);
        check({name, " busy_cycles"}, nb + 1, W);
        check({name, " sum"}, sum, es);
        check({name, " cout"}, cout, ec);
        check({name, " ovf"}, ovf, eo);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok; int nb; int d[$]; int cyc;
        #2;
        check("reset sum", sum, 0);
        check("reset flags", {cout, ovf, busy, done}, 0);
        @(negedge clk); #1 rst_n = 1;

        run_op(4'b0011, 4'b0101, 0, "add3+5", 4'b1000, 0, 1);
        run_op(4'b1111, 4'b0001, 0, "add15+1", 4'b0000, 1, 0);
        run_op(4'b0000, 4'b0000, 0, "add0+0", 4'b0000, 0, 0);
        run_op(4'b0101, 4'b0011, 1, "sub5-3", 4'b0010, 1, 0);
        run_op(4'b0011, 4'b0101, 1, "sub3-5", 4'b1110, 0, 0);
        run_op(4'b1000, 4'b0001, 1, "sub8-1", 4'b0111, 1, 1);

        // start re-pulsed in RUN and DONE must be ignored
        launch(4'b0101, 4'b0011, 1, "ignore");
        @(negedge clk); #1 start = 1; a = 4'b1111; b = 4'b1111; sub = 0;
        @(negedge clk); #1 start = 0;
        wait_done(ok, nb);
        check("ignore done", ok, 1);
        #1 start = 1; a = 4'b0111; b = 4'b0111; sub = 0;
        @(negedge clk);
        check("ignore sum", sum, 4'b0010);
        check("ignore no_accept", busy, 0);
        #1 start = 0;

        // asynchronous reset mid-run
        launch(4'b0111, 4'b0110, 0, "rst");
        @(negedge clk); #1 rst_n = 0;
        #1;
        check("rst sum", sum, 0);
        check("rst flags", {cout, ovf, busy, done}, 0);
        #3 rst_n = 1;
        run_op(4'b0010, 4'b0011, 0, "after_rst", 4'b0101, 0, 0);

        // start held high: done every W+2 cycles
        @(negedge clk); #1 start = 1;
        cyc = 0;
        for (int i = 0; i < 40 && d.size() < 3; i++) begin
            @(negedge clk);
            cyc++;
            if (done) d.push_back(cyc);
            #1 a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
        end
        start = 0;
        check("held dones", d.size(), 3);
        if (d.size() == 3) begin
            check("held gap1", d[1] - d[0], W + 2);
            check("held gap2", d[2] - d[1], W + 2);
        end

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            @(negedge clk); #1;
            start = ($urandom_range(0, 2) == 0);
            a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
        end
        start = 0;
        repeat (10) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
